// File: rtl/dma_channel_scheduler.sv
// ---------------------------------------------------------------------------
// dma_channel_scheduler
//
// Purpose:
//   Multi-channel front end for a single-port memory copy engine. Each of NCH
//   requesters posts a copy descriptor (source, destination, word count). A
//   round-robin arbiter hands the shared memory port to one channel at a time.
//   The granted copy runs as alternating READ/WRITE cycles, one word each.
//   When the copy finishes, the owning channel gets a one-cycle done pulse.
//
// Ports:
//   clk        in   1        clock, rising edge
//   rst        in   1        synchronous reset, active high
//   ch_req     in   NCH      per-channel request pulse (descriptor sampled same edge)
//   ch_src     in   NCH*AW   per-channel source start address, channel i at [i*AW +: AW]
//   ch_dst     in   NCH*AW   per-channel destination start address
//   ch_len     in   NCH*LW   per-channel word count (0 allowed)
//   ch_grant   out  NCH      one-hot owner of the memory port
//   ch_done    out  NCH      one-cycle completion pulse
//   busy       out  1        scheduler not idle
//   mem_addr   out  AW       memory address
//   mem_wdata  out  DW       memory write data
//   mem_rdata  in   DW       memory read data (combinational from mem_addr)
//   mem_ce_n   out  1        chip enable, active low
//   mem_we_n   out  1        write enable, active low
//
// Handshake:
//   ch_req[i] is a pulse, not a valid/ready pair. It is accepted on the edge
//   where it is seen only if channel i has no pending descriptor and does not
//   currently own the port (this includes its DONE cycle). Otherwise it is
//   dropped silently. The requester sees acceptance indirectly, through
//   ch_grant and ch_done.
// ---------------------------------------------------------------------------
module dma_channel_scheduler #(
  parameter int NCH = 4,
  parameter int AW  = 4,
  parameter int DW  = 8,
  parameter int LW  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH*AW-1:0] ch_src,
  input  logic [NCH*AW-1:0] ch_dst,
  input  logic [NCH*LW-1:0] ch_len,
  output logic [NCH-1:0]    ch_grant,
  output logic [NCH-1:0]    ch_done,
  output logic              busy,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  output logic              mem_ce_n,
  output logic              mem_we_n
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // FSM and arbitration state
  logic [1:0]        state_q,      state_d;
  logic [NCH-1:0]    pending_q,    pending_d;
  logic [NCH-1:0]    grant_q,      grant_d;
  logic [IW-1:0]     rr_q,         rr_d;

  // Per-channel descriptors latched at request time
  logic [NCH*AW-1:0] desc_src_q,   desc_src_d;
  logic [NCH*AW-1:0] desc_dst_q,   desc_dst_d;
  logic [NCH*LW-1:0] desc_len_q,   desc_len_d;

  // Working copy of the active transfer
  logic [AW-1:0]     cur_src_q,    cur_src_d;
  logic [AW-1:0]     cur_dst_q,    cur_dst_d;
  logic [LW-1:0]     cur_cnt_q,    cur_cnt_d;
  logic [DW-1:0]     data_q,       data_d;

  // Last driven address/data. These let mem_addr and mem_wdata hold their
  // values outside READ/WRITE without a separate output register per state.
  logic [AW-1:0]     addr_hold_q;
  logic [DW-1:0]     wdata_hold_q;

  // Round-robin winner search: start one past the last winner and wrap.
  logic              win_found;
  logic [IW-1:0]     win_idx;
  logic [IW-1:0]     cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NCH; k++) begin
      cand = IW'((int'(rr_q) + k) % NCH);
      if (!win_found && pending_q[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    desc_src_d = desc_src_q;
    desc_dst_d = desc_dst_q;
    desc_len_d = desc_len_q;
    cur_src_d  = cur_src_q;
    cur_dst_d  = cur_dst_q;
    cur_cnt_d  = cur_cnt_q;
    data_d     = data_q;

    // Request capture uses the registered pending/grant. A channel that wins
    // on this same edge still has pending_q set, so its own request is dropped.
    for (int i = 0; i < NCH; i++) begin
      if (ch_req[i] && !pending_q[i] && !grant_q[i]) begin
        pending_d[i]               = 1'b1;
        desc_src_d[i*AW +: AW]     = ch_src[i*AW +: AW];
        desc_dst_d[i*AW +: AW]     = ch_dst[i*AW +: AW];
        desc_len_d[i*LW +: LW]     = ch_len[i*LW +: LW];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          pending_d[win_idx] = 1'b0;
          cur_src_d          = desc_src_q[int'(win_idx)*AW +: AW];
          cur_dst_d          = desc_dst_q[int'(win_idx)*AW +: AW];
          cur_cnt_d          = desc_len_q[int'(win_idx)*LW +: LW];
          grant_d            = '0;
          grant_d[win_idx]   = 1'b1;
          rr_d               = win_idx;
          // A zero-length descriptor skips straight to its done pulse.
          if (desc_len_q[int'(win_idx)*LW +: LW] == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        data_d  = mem_rdata;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        // Addresses wrap silently modulo 2^AW.
        cur_src_d = cur_src_q + AW'(1);
        cur_dst_d = cur_dst_q + AW'(1);
        cur_cnt_d = cur_cnt_q - LW'(1);
        if (cur_cnt_q == LW'(1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_READ;
        end
      end
      S_DONE: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode, from registered state only
  always_comb begin
    busy     = (state_q != S_IDLE);
    ch_grant = grant_q;
    ch_done  = (state_q == S_DONE) ? grant_q : '0;
    mem_ce_n = !((state_q == S_READ) || (state_q == S_WRITE));
    mem_we_n = (state_q != S_WRITE);
    case (state_q)
      S_READ:  mem_addr = cur_src_q;
      S_WRITE: mem_addr = cur_dst_q;
      default: mem_addr = addr_hold_q;
    endcase
    mem_wdata = (state_q == S_WRITE) ? data_q : wdata_hold_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pending_q    <= '0;
      grant_q      <= '0;
      rr_q         <= IW'(NCH - 1);
      desc_src_q   <= '0;
      desc_dst_q   <= '0;
      desc_len_q   <= '0;
      cur_src_q    <= '0;
      cur_dst_q    <= '0;
      cur_cnt_q    <= '0;
      data_q       <= '0;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      grant_q      <= grant_d;
      rr_q         <= rr_d;
      desc_src_q   <= desc_src_d;
      desc_dst_q   <= desc_dst_d;
      desc_len_q   <= desc_len_d;
      cur_src_q    <= cur_src_d;
      cur_dst_q    <= cur_dst_d;
      cur_cnt_q    <= cur_cnt_d;
      data_q       <= data_d;
      addr_hold_q  <= mem_addr;
      wdata_hold_q <= mem_wdata;
    end
  end

endmodule
